mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
MEM-stage load/store unit that consumes the EX/MEM pipeline register outputs: memory control, ALU address and store data. It drives a variable-latency data-memory bus with a req/ready handshake. It stalls the pipeline (freezing EX/MEM) until an access completes, then returns sign- or zero-extended load data to the MEM/WB path. It also detects misaligned accesses.

Parameters:
DATA_W, 32, data/ALU width; byte-lane logic fixed to 4 lanes
ADDR_W, 9, word-index width of data-memory address

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
MemRead  in  3  load op: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 110/111 none
MemWrite  in  2  store op: 00 none, 01 SB, 10 SH, 11 SW
ALUResult  in  DATA_W  byte address
Reg2  in  DATA_W  store data
mem_req  out  1  bus request
mem_we  out  1  1=write
mem_addr  out  ADDR_W  word index = ALUResult[ADDR_W+1:2]
mem_be  out  4  byte enables
mem_wdata  out  DATA_W  lane-replicated store data
mem_rdata  in  DATA_W  read word; valid when mem_ready=1
mem_ready  in  1  completes the current request
lsu_stall  out  1  hold IF/ID/EX/EX-MEM
load_data  out  DATA_W  extended load result
load_valid  out  1  one-cycle pulse, load_data valid
misalign_err  out  1  one-cycle pulse

Behaviour:
- Reset (async, immediate): state=IDLE. mem_req, mem_we, mem_be, mem_addr, mem_wdata, load_data, load_valid, misalign_err, lsu_stall all 0. An in-flight request is abandoned and mem_req drops without waiting for mem_ready.
- Op present: MemRead in 001..101 or MemWrite!=00. Both nonzero: the load wins; the store is ignored.
- Misaligned: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0. In IDLE, misalign_err pulses for 1 cycle, with no request and no stall. For a misaligned load, load_valid=1 and load_data=0.
- States:
  - IDLE:
    - Aligned op: lsu_stall=1 (combinational); register addr/be/we/wdata; set mem_req=1; go BUSY.
    - No op: lsu_stall=0.
  - BUSY:
    - mem_req=1; lsu_stall=1.
    - Edge with mem_ready=1: capture extended read data; mem_req=0; go DONE.
    - Outputs are stable while waiting.
  - DONE:
    - lsu_stall=0; load_valid=1 for loads only; load_data held until the next load completes.
    - Go IDLE unconditionally, so the same op is never reissued because EX/MEM advances on this edge.
- Latency:
  - Op seen at cycle N.
  - mem_req high N+1..ready.
  - mem_ready at N+1 gives DONE at N+2.
  - Minimum 3 cycles, 2 stalled.
- Lanes, with o = addr[1:0]:
  - SB: be=0001<<o; wdata={4{Reg2[7:0]}}.
  - SH: be=0011<<o; wdata={2{Reg2[15:0]}}.
  - SW: be=1111; wdata=Reg2.
  - Loads: be=1111, we=0.
- Extract: lane = mem_rdata>>(8*o). LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- mem_ready outside BUSY is ignored.

Optional Feature:
- Macro: STORE_BUFFER_EN.
- Defined: a 1-entry posted store buffer.
  - Aligned store in IDLE with buffer empty: captured, lsu_stall=0, no DONE. The buffer drives mem_req from the next cycle until mem_ready, then empties.
  - Store with buffer full: stall until the drain edge, then capture.
  - Load with buffer full: stall until drained, then the normal load FSM.
  - Reset clears the buffer.
- Undefined: stores use the IDLE/BUSY/DONE path like loads, with no load_valid.

Test Plan:
- LW addr 0x10, mem_rdata=0xDEADBEEF, ready at first req cycle → mem_addr=4, be=1111, lsu_stall 2 cycles, load_valid 1 cycle, load_data=0xDEADBEEF.
- LB addr 0x13, rdata=0x80123456 → be=1111, load_data=0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x12 → 0x00008012.
- SH addr 0x06, Reg2=0x0000ABCD, ready after 3 wait cycles → mem_we=1, be=1100, wdata=0xABCDABCD, mem_addr=1, stall holds through wait, no load_valid.
- LW addr 0x01 → misalign_err pulse, mem_req never asserted, lsu_stall=0, load_data=0.
- Reset asserted in BUSY before mem_ready → mem_req=0 and lsu_stall=0 immediately, IDLE after release, a later ready pulse ignored.
- STORE_BUFFER_EN: SW then LW back-to-back, ready delayed 2 cycles → store causes no stall, LW stalls until store drained then completes normally.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ready data-memory bus, pipeline stall, load extension, misalign detect.
// Optional feature: define STORE_BUFFER_EN for a 1-entry posted store buffer.
module mem_stage_lsu #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        MemRead,
   input  logic [1:0]        MemWrite,
   input  logic [DATA_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] Reg2,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              lsu_stall,
   output logic [DATA_W-1:0] load_data,
   output logic              load_valid,
   output logic              misalign_err
);
   localparam logic [2:0] LD_LB  = 3'b001;
   localparam logic [2:0] LD_LH  = 3'b010;
   localparam logic [2:0] LD_LW  = 3'b011;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;
   localparam logic [1:0] ST_SB  = 2'b01;
   localparam logic [1:0] ST_SH  = 2'b10;
   localparam logic [1:0] ST_SW  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_req, w_req_nxt;
   logic                r_we, w_we_nxt;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
   logic [3:0]          r_be, w_be_nxt;
   logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
   logic [2:0]          r_ld_op, w_ld_op_nxt;
   logic [1:0]          r_off, w_off_nxt;
   logic                r_is_ld, w_is_ld_nxt;
   logic [DATA_W-1:0]   r_ld_data, w_ld_data_nxt;
   logic                r_ld_valid, w_ld_valid_nxt;
   logic                r_mis, w_mis_nxt;
`ifdef STORE_BUFFER_EN
   logic                r_sb_valid, w_sb_nxt;
`endif

   logic                w_is_load, w_is_store, w_op, w_misalign, w_stall, w_capture;
   logic [1:0]          w_off;
   logic [3:0]          w_be;
   logic [DATA_W-1:0]   w_wdata, w_lane, w_ext;
   logic                w_unused_addr;

   assign w_off         = ALUResult[1:0];
   assign w_unused_addr = ^ALUResult[DATA_W-1:ADDR_W+2];
   assign w_is_load     = (MemRead >= LD_LB) && (MemRead <= LD_LHU);
   assign w_is_store    = !w_is_load && (MemWrite != 2'b00);
   assign w_op          = w_is_load || w_is_store;

   // Alignment, byte enables and lane-replicated store data for the op in EX/MEM
   always_comb begin
      w_misalign = 1'b0;
      w_be       = 4'hF;
      w_wdata    = '0;
      if (w_is_load) begin
         case (MemRead)
            LD_LH, LD_LHU: w_misalign = w_off[0];
            LD_LW:         w_misalign = |w_off;
            default:       w_misalign = 1'b0;
         endcase
      end else begin
         case (MemWrite)
            ST_SB: begin
               w_be    = 4'(4'b0001 << w_off);
               w_wdata = DATA_W'({4{Reg2[7:0]}});
            end
            ST_SH: begin
               w_misalign = w_off[0];
               w_be       = 4'(4'b0011 << w_off);
               w_wdata    = DATA_W'({2{Reg2[15:0]}});
            end
            ST_SW: begin
               w_misalign = |w_off;
               w_wdata    = Reg2;
            end
            default: w_wdata = '0;
         endcase
      end
   end

   assign w_lane = mem_rdata >> {r_off, 3'b000};

   always_comb begin
      case (r_ld_op)
         LD_LB:   w_ext = {{(DATA_W-8){w_lane[7]}}, w_lane[7:0]};
         LD_LH:   w_ext = {{(DATA_W-16){w_lane[15]}}, w_lane[15:0]};
         LD_LBU:  w_ext = DATA_W'(w_lane[7:0]);
         LD_LHU:  w_ext = DATA_W'(w_lane[15:0]);
         default: w_ext = w_lane;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      w_state_nxt    = r_state;
      w_req_nxt      = r_req;
      w_we_nxt       = r_we;
      w_addr_nxt     = r_addr;
      w_be_nxt       = r_be;
      w_wdata_nxt    = r_wdata;
      w_ld_op_nxt    = r_ld_op;
      w_off_nxt      = r_off;
      w_is_ld_nxt    = r_is_ld;
      w_ld_data_nxt  = r_ld_data;
      w_ld_valid_nxt = 1'b0;
      w_mis_nxt      = 1'b0;
      w_stall        = 1'b0;
      w_capture      = 1'b0;
`ifdef STORE_BUFFER_EN
      w_sb_nxt = r_sb_valid;
      if (r_sb_valid && mem_ready) begin
         w_sb_nxt  = 1'b0;
         w_req_nxt = 1'b0;
      end
`endif
      case (r_state)
         S_IDLE: begin
            if (w_op) begin
               if (w_misalign) begin
                  w_mis_nxt = 1'b1;
                  if (w_is_load) begin
                     w_ld_valid_nxt = 1'b1;
                     w_ld_data_nxt  = '0;
                  end
               end
`ifdef STORE_BUFFER_EN
               else if (r_sb_valid && !mem_ready) begin
                  w_stall = 1'b1;
               end else if (w_is_store) begin
                  w_capture = 1'b1;
                  w_sb_nxt  = 1'b1;
               end
`endif
               else begin
                  w_stall     = 1'b1;
                  w_capture   = 1'b1;
                  w_state_nxt = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            w_stall = 1'b1;
            if (mem_ready) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = S_DONE;
               if (r_is_ld) begin
                  w_ld_data_nxt  = w_ext;
                  w_ld_valid_nxt = 1'b1;
               end
            end
         end
         // EX/MEM advances on this edge, so never reissue the completed op
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_capture) begin
         w_req_nxt   = 1'b1;
         w_we_nxt    = w_is_store;
         w_addr_nxt  = ALUResult[ADDR_W+1:2];
         w_be_nxt    = w_be;
         w_wdata_nxt = w_wdata;
         w_ld_op_nxt = MemRead;
         w_off_nxt   = w_off;
         w_is_ld_nxt = w_is_load;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_req      <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_be       <= '0;
         r_wdata    <= '0;
         r_ld_op    <= '0;
         r_off      <= '0;
         r_is_ld    <= 1'b0;
         r_ld_data  <= '0;
         r_ld_valid <= 1'b0;
         r_mis      <= 1'b0;
`ifdef STORE_BUFFER_EN
         r_sb_valid <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_req      <= w_req_nxt;
         r_we       <= w_we_nxt;
         r_addr     <= w_addr_nxt;
         r_be       <= w_be_nxt;
         r_wdata    <= w_wdata_nxt;
         r_ld_op    <= w_ld_op_nxt;
         r_off      <= w_off_nxt;
         r_is_ld    <= w_is_ld_nxt;
         r_ld_data  <= w_ld_data_nxt;
         r_ld_valid <= w_ld_valid_nxt;
         r_mis      <= w_mis_nxt;
`ifdef STORE_BUFFER_EN
         r_sb_valid <= w_sb_nxt;
`endif
      end
   end

   assign mem_req      = r_req;
   assign mem_we       = r_we;
   assign mem_addr     = r_addr;
   assign mem_be       = r_be;
   assign mem_wdata    = r_wdata;
   assign load_data    = r_ld_data;
   assign load_valid   = r_ld_valid;
   assign misalign_err = r_mis;
   assign lsu_stall    = w_stall & ~rst;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized ops against a transaction-level model.
module tb_mem_stage_lsu;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  MemRead;
   logic [1:0]  MemWrite;
   logic [31:0] ALUResult, Reg2;
   logic        mem_req, mem_we;
   logic [8:0]  mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_ready, lsu_stall;
   logic [31:0] load_data;
   logic        load_valid, misalign_err;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_hold = '0;

   typedef struct { logic we; logic [8:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;
   typedef struct { bit mis; logic [2:0] op; logic [1:0] off; } ld_t;

   always #5 clk = ~clk;

   mem_stage_lsu #(.DATA_W(32), .ADDR_W(9)) dut (
      .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
      .ALUResult(ALUResult), .Reg2(Reg2), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .lsu_stall(lsu_stall),
      .load_data(load_data), .load_valid(load_valid), .misalign_err(misalign_err)
   );

   function automatic int ld_size(input logic [2:0] op);
      case (op)
         3'b001, 3'b100: return 1;
         3'b010, 3'b101: return 2;
         3'b011:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic int st_size(input logic [1:0] mw);
      case (mw)
         2'b01:   return 1;
         2'b10:   return 2;
         2'b11:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] m_extract(input logic [2:0] op, input logic [1:0] off, input logic [31:0] w);
      longint v, span;
      int n;
      bit sgn;
      n    = ld_size(op);
      sgn  = (op == 3'b001) || (op == 3'b010);
      span = longint'(1) << (8 * n);
      v    = longint'({32'd0, w}) >> (8 * int'(off));
      v    = v % span;
      if (sgn && v >= span / 2) v = v - span;
      return 32'(v);
   endfunction

   function automatic logic [31:0] m_repl(input logic [31:0] d, input int n);
      longint unit, r;
      unit = longint'({32'd0, d}) % (longint'(1) << (8 * n));
      r = 0;
      for (int k = 0; k < 4 / n; k++) r = r + unit * (longint'(1) << (8 * n * k));
      return 32'(r);
   endfunction

   // Presents one op, holds it while stalled, answers the bus after 'waits' wait cycles and reports what it saw
   task automatic run_op(input logic [2:0] mr, input logic [1:0] mw, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input int waits,
                         output int n_st, output int n_req, output int n_lv, output int n_mis,
                         output logic [31:0] ld, output logic [3:0] be, output logic [31:0] wd,
                         output logic [8:0] ad, output logic we);
      logic st;
      n_st = 0; n_req = 0; n_lv = 0; n_mis = 0;
      ld = '0; be = '0; wd = '0; ad = '0; we = 1'b0;
      @(posedge clk); #1;
      MemRead = mr; MemWrite = mw; ALUResult = a; Reg2 = d;
      for (int c = 0; c < waits + 8; c++) begin
         @(negedge clk);
         if (mem_req) begin
            if (n_req == 0) begin be = mem_be; wd = mem_wdata; ad = mem_addr; we = mem_we; end
            n_req++;
            if (n_req == waits + 1) begin mem_ready = 1'b1; mem_rdata = rd; end
         end
         if (load_valid) begin n_lv++; ld = load_data; end
         if (misalign_err) n_mis++;
         #1 st = lsu_stall;
         if (st) n_st++;
         @(posedge clk); #1;
         mem_ready = 1'b0;
         if (!st) begin MemRead = '0; MemWrite = '0; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({mem_req, mem_we, mem_addr, mem_be, lsu_stall, load_valid, misalign_err} !== '0) begin
         bad++;
         $display("FAIL reset_ctrl: req=%b we=%b addr=%h be=%b stall=%b lv=%b mis=%b, all expected 0",
                  mem_req, mem_we, mem_addr, mem_be, lsu_stall, load_valid, misalign_err);
      end
      total++;
      if ({mem_wdata, load_data} !== 64'd0) begin
         bad++;
         $display("FAIL reset_data: wdata=%h load_data=%h expected 0", mem_wdata, load_data);
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_lw;
      int st, rq, lv, mi; logic [31:0] ld, wd; logic [3:0] be; logic [8:0] ad; logic we;
      run_op(3'b011, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 0, st, rq, lv, mi, ld, be, wd, ad, we);
      total++; if (ad !== 9'd4) begin bad++; $display("FAIL lw_addr: got %0d expected 4", ad); end
      total++; if (be !== 4'hF || we !== 1'b0) begin bad++; $display("FAIL lw_be_we: be=%b we=%b expected 1111/0", be, we); end
      total++; if (st !== 2 || rq !== 1) begin bad++; $display("FAIL lw_timing: stall=%0d req=%0d expected 2/1", st, rq); end
      total++; if (lv !== 1 || ld !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data: lv=%0d data=%h expected 1/deadbeef", lv, ld); end
      exp_hold = 32'hDEADBEEF;
   endtask

   task automatic test_extend;
      logic [2:0]  ops   [3] = '{3'b001, 3'b100, 3'b101};
      logic [31:0] addrs [3] = '{32'h13, 32'h13, 32'h12};
      int st, rq, lv, mi; logic [31:0] ld, wd, ex; logic [3:0] be; logic [8:0] ad; logic we;
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i], 2'b00, addrs[i], 32'h0, 32'h80123456, i, st, rq, lv, mi, ld, be, wd, ad, we);
         ex = m_extract(ops[i], addrs[i][1:0], 32'h80123456);
         total++;
         if (lv !== 1 || ld !== ex || be !== 4'hF || ad !== 9'd4) begin
            bad++;
            $display("FAIL extend_%0d: lv=%0d data=%h be=%b addr=%0d expected 1/%h/1111/4", i, lv, ld, be, ad, ex);
         end
         exp_hold = ex;
      end
   endtask

   task automatic test_store_sh;
      int st, rq, lv, mi, exp_st; logic [31:0] ld, wd; logic [3:0] be; logic [8:0] ad; logic we;
`ifdef STORE_BUFFER_EN
      exp_st = 0;
`else
      exp_st = 5;
`endif
      run_op(3'b000, 2'b10, 32'h06, 32'h0000ABCD, 32'h0, 3, st, rq, lv, mi, ld, be, wd, ad, we);
      total++; if (we !== 1'b1 || be !== 4'b1100 || ad !== 9'd1) begin bad++; $display("FAIL sh_ctrl: we=%b be=%b addr=%0d expected 1/1100/1", we, be, ad); end
      total++; if (wd !== 32'hABCDABCD) begin bad++; $display("FAIL sh_wdata: got %h expected abcdabcd", wd); end
      total++; if (st !== exp_st || rq !== 4 || lv !== 0) begin bad++; $display("FAIL sh_timing: stall=%0d req=%0d lv=%0d expected %0d/4/0", st, rq, lv, exp_st); end
      total++; if (load_data !== exp_hold) begin bad++; $display("FAIL sh_hold: load_data=%h expected %h", load_data, exp_hold); end
   endtask

   task automatic test_misalign;
      int st, rq, lv, mi; logic [31:0] ld, wd; logic [3:0] be; logic [8:0] ad; logic we;
      run_op(3'b011, 2'b00, 32'h01, 32'h0, 32'h55555555, 0, st, rq, lv, mi, ld, be, wd, ad, we);
      total++; if (mi !== 1 || rq !== 0 || st !== 0) begin bad++; $display("FAIL mis_lw: mis=%0d req=%0d stall=%0d expected 1/0/0", mi, rq, st); end
      total++; if (lv !== 1 || ld !== 32'h0) begin bad++; $display("FAIL mis_lw_data: lv=%0d data=%h expected 1/0", lv, ld); end
      run_op(3'b000, 2'b11, 32'h02, 32'h12345678, 32'h0, 0, st, rq, lv, mi, ld, be, wd, ad, we);
      total++; if (mi !== 1 || rq !== 0 || st !== 0 || lv !== 0) begin bad++; $display("FAIL mis_sw: mis=%0d req=%0d stall=%0d lv=%0d expected 1/0/0/0", mi, rq, st, lv); end
      run_op(3'b101, 2'b00, 32'h03, 32'h0, 32'h0, 0, st, rq, lv, mi, ld, be, wd, ad, we);
      total++; if (mi !== 1 || rq !== 0 || lv !== 1) begin bad++; $display("FAIL mis_lhu: mis=%0d req=%0d lv=%0d expected 1/0/1", mi, rq, lv); end
      exp_hold = 32'h0;
   endtask

   task automatic test_reset_busy;
      int n, st, rq, lv, mi; logic [31:0] ld, wd, rd; logic [3:0] be; logic [8:0] ad; logic we;
      @(posedge clk); #1;
      MemRead = 3'b011; MemWrite = 2'b00; ALUResult = 32'h20;
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_req && n < 10);
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstbusy_req: mem_req=%b expected 1", mem_req); end
      rst = 1'b1;
      #1;
      total++; if (mem_req !== 1'b0 || lsu_stall !== 1'b0) begin bad++; $display("FAIL rstbusy_now: req=%b stall=%b expected 0/0", mem_req, lsu_stall); end
      MemRead = '0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
      @(posedge clk); #1 mem_ready = 1'b0;
      n = 0;
      repeat (4) begin @(negedge clk); if (mem_req || load_valid || lsu_stall) n++; end
      total++; if (n !== 0) begin bad++; $display("FAIL rstbusy_ignore: %0d active cycles expected 0", n); end
      rd = $urandom;
      run_op(3'b011, 2'b00, 32'h24, 32'h0, rd, 1, st, rq, lv, mi, ld, be, wd, ad, we);
      total++; if (st !== 3 || lv !== 1 || ld !== rd || ad !== 9'd9) begin bad++; $display("FAIL rstbusy_after: stall=%0d lv=%0d data=%h addr=%0d expected 3/1/%h/9", st, lv, ld, ad, rd); end
      exp_hold = rd;
   endtask

   task automatic test_back_to_back;
      int sw_st, lw_st, lv_cyc, reqn, nreqs, phase, exp_sw, exp_lw, exp_lv;
      logic st; logic [31:0] rd, ld; logic rq_we [2]; logic [8:0] rq_ad [2];
`ifdef STORE_BUFFER_EN
      exp_sw = 0; exp_lw = 6; exp_lv = 7;
`else
      exp_sw = 4; exp_lw = 4; exp_lv = 9;
`endif
      sw_st = 0; lw_st = 0; lv_cyc = -1; reqn = 0; nreqs = 0; phase = 0; ld = '0;
      rq_we = '{1'b0, 1'b1}; rq_ad = '{9'd0, 9'd0};
      rd = $urandom;
      @(posedge clk); #1;
      MemRead = 3'b000; MemWrite = 2'b11; ALUResult = 32'h40; Reg2 = $urandom;
      for (int cyc = 0; cyc < 40 && lv_cyc < 0; cyc++) begin
         @(negedge clk);
         if (mem_req) begin
            if (reqn == 0 && nreqs < 2) begin rq_we[nreqs] = mem_we; rq_ad[nreqs] = mem_addr; end
            reqn++;
            if (reqn == 3) begin mem_ready = 1'b1; mem_rdata = rd; nreqs++; end
         end
         if (load_valid) begin lv_cyc = cyc; ld = load_data; end
         #1 st = lsu_stall;
         if (st) begin if (phase == 0) sw_st++; else lw_st++; end
         @(posedge clk); #1;
         if (mem_ready) begin mem_ready = 1'b0; reqn = 0; end
         if (!st && phase == 0) begin
            MemWrite = 2'b00; MemRead = 3'b011; ALUResult = 32'h44; phase = 1;
         end else if (!st && phase == 1) begin
            MemRead = 3'b000; phase = 2;
         end
      end
      total++; if (sw_st !== exp_sw || lw_st !== exp_lw) begin bad++; $display("FAIL b2b_stall: sw=%0d lw=%0d expected %0d/%0d", sw_st, lw_st, exp_sw, exp_lw); end
      total++; if (lv_cyc !== exp_lv || ld !== rd) begin bad++; $display("FAIL b2b_load: cycle=%0d data=%h expected %0d/%h", lv_cyc, ld, exp_lv, rd); end
      total++;
      if (nreqs !== 2 || rq_we[0] !== 1'b1 || rq_ad[0] !== 9'h10 || rq_we[1] !== 1'b0 || rq_ad[1] !== 9'h11) begin
         bad++;
         $display("FAIL b2b_order: n=%0d we0=%b ad0=%h we1=%b ad1=%h expected 2/1/010/0/011", nreqs, rq_we[0], rq_ad[0], rq_we[1], rq_ad[1]);
      end
      exp_hold = rd;
   endtask

   task automatic test_random;
      bus_t busq[$]; ld_t lq[$]; logic [31:0] rdq[$];
      bus_t ex, cur; ld_t le;
      logic [31:0] exp_v, rd;
      logic [1:0] off;
      logic st, need, real_rdy, unstable, is_ld;
      int nops, issued, exp_mis, got_mis, reqn, wait_n, idle, n;
      nops = 80; issued = 0; exp_mis = 0; got_mis = 0; reqn = 0; wait_n = 0; idle = 0;
      need = 1'b1; st = 1'b0; unstable = 1'b0;
      cur = '{1'b0, 9'd0, 4'd0, 32'd0};
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 3000 && idle < 30; cyc++) begin
         if (need) begin
            need = 1'b0;
            if (issued < nops && $urandom_range(0, 3) != 0) begin
               MemRead = 3'($urandom_range(0, 7)); MemWrite = 2'($urandom_range(0, 3));
               ALUResult = $urandom; Reg2 = $urandom;
               issued++;
               is_ld = ld_size(MemRead) != 0;
               n = is_ld ? ld_size(MemRead) : st_size(MemWrite);
               off = ALUResult[1:0];
               if (n != 0) begin
                  if (int'(off) % n != 0) begin
                     exp_mis++;
                     if (is_ld) lq.push_back('{1'b1, MemRead, off});
                  end else begin
                     ex.we = !is_ld;
                     ex.addr = 9'((ALUResult >> 2) % 512);
                     ex.be = is_ld ? 4'hF : 4'(((1 << n) - 1) << off);
                     ex.wdata = m_repl(Reg2, n);
                     busq.push_back(ex);
                     if (is_ld) lq.push_back('{1'b0, MemRead, off});
                  end
               end
            end else begin
               MemRead = '0; MemWrite = '0;
               if (issued >= nops) idle++;
            end
         end
         @(negedge clk);
         real_rdy = 1'b0;
         if (mem_req) begin
            if (reqn == 0) begin
               total++;
               if (busq.size() == 0) begin
                  bad++; $display("FAIL rnd_unexpected_req: addr=%h we=%b with no request expected", mem_addr, mem_we);
               end else begin
                  ex = busq.pop_front();
                  if (mem_we !== ex.we || mem_addr !== ex.addr || mem_be !== ex.be || (ex.we && mem_wdata !== ex.wdata)) begin
                     bad++;
                     $display("FAIL rnd_bus: we=%b addr=%h be=%b wdata=%h expected %b/%h/%b/%h",
                              mem_we, mem_addr, mem_be, mem_wdata, ex.we, ex.addr, ex.be, ex.wdata);
                  end
               end
               cur.we = mem_we; cur.addr = mem_addr; cur.be = mem_be; cur.wdata = mem_wdata;
               wait_n = $urandom_range(0, 3); unstable = 1'b0;
            end else if (mem_we !== cur.we || mem_addr !== cur.addr || mem_be !== cur.be || mem_wdata !== cur.wdata) begin
               unstable = 1'b1;
            end
            reqn++;
            if (reqn > wait_n) begin
               total++;
               if (unstable) begin bad++; $display("FAIL rnd_stable: bus changed while waiting, addr=%h expected %h", mem_addr, cur.addr); end
               rd = $urandom; mem_ready = 1'b1; mem_rdata = rd; real_rdy = 1'b1;
               if (!cur.we) rdq.push_back(rd);
            end
         end else if ($urandom_range(0, 3) == 0) begin
            mem_ready = 1'b1; mem_rdata = $urandom;
         end
         if (load_valid) begin
            total++;
            if (lq.size() == 0) begin
               bad++; $display("FAIL rnd_unexpected_lv: data=%h with no load expected", load_data);
            end else begin
               le = lq.pop_front();
               if (le.mis) exp_v = '0;
               else if (rdq.size() != 0) exp_v = m_extract(le.op, le.off, rdq.pop_front());
               else exp_v = 32'hXXXXXXXX;
               if (load_data !== exp_v) begin bad++; $display("FAIL rnd_load: data=%h expected %h", load_data, exp_v); end
            end
         end
         if (misalign_err) got_mis++;
         #1 st = lsu_stall;
         @(posedge clk); #1;
         mem_ready = 1'b0;
         if (real_rdy) reqn = 0;
         if (!st) need = 1'b1;
      end
      total++; if (issued !== nops || busq.size() !== 0) begin bad++; $display("FAIL rnd_drain: issued=%0d pending_req=%0d expected %0d/0", issued, busq.size(), nops); end
      total++; if (lq.size() !== 0 || rdq.size() !== 0) begin bad++; $display("FAIL rnd_loads: pending=%0d unused_rdata=%0d expected 0/0", lq.size(), rdq.size()); end
      total++; if (got_mis !== exp_mis) begin bad++; $display("FAIL rnd_misalign: got=%0d expected %0d", got_mis, exp_mis); end
   endtask

   initial begin
      rst = 1'b1; MemRead = '0; MemWrite = '0; ALUResult = '0; Reg2 = '0;
      mem_rdata = '0; mem_ready = 1'b0;
      test_reset();
      test_lw();
      test_extend();
      test_store_sh();
      test_misalign();
      test_reset_busy();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1);
   end
endmodule
